// File: rtl/chi_link_pkg.sv
// rtl/chi_link_pkg.sv - shared link FSM states and CHI credit constants
package chi_link_pkg;

    typedef enum logic [1:0] {
        STOP       = 2'd0,
        ACTIVATE   = 2'd1,
        RUN        = 2'd2,
        DEACTIVATE = 2'd3
    } link_state_t;

    localparam int CHI_MAX_CREDITS = 15;
    localparam logic [6:0] LCRD_RETURN_OPCODE = 7'd0;

endpackage

// File: rtl/chi_link_tx_scheduler_arbiter.sv
// rtl/chi_link_tx_scheduler_arbiter.sv - chi_rr_arbiter: round-robin one-hot grant with rotating pointer
module chi_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] ptr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] next_ptr;
    logic             found;

    // Scan from ptr upward with wrap; first requesting index wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ptr <= '0;
        else if (advance)
            ptr <= next_ptr;
    end

endmodule

// File: rtl/chi_link_tx_scheduler.sv
// rtl/chi_link_tx_scheduler.sv - CHI TX link FSM, credits and RR flit scheduling (option: CHI_TX_SCHED_RESV_EN)
module chi_link_tx_scheduler
    import chi_link_pkg::*;
#(
    parameter int FLIT_W      = 128,
    parameter int NUM_REQ     = 4,
    parameter int MAX_CREDITS = CHI_MAX_CREDITS
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      link_en,
    output logic                      txlinkactivereq,
    input  logic                      txlinkactiveack,
    output logic                      txflitpend,
    output logic                      txflitv,
    output logic [FLIT_W-1:0]         txflit,
    input  logic                      txlcrdv,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [3:0]                cur_credits,
    output logic [1:0]                link_state,
    output logic                      credit_err
);

    localparam logic [3:0] CRED_MAX = 4'(MAX_CREDITS);

    link_state_t                  state;
    logic [3:0]                   credits;
    logic                         lcrd_in;
    logic [NUM_REQ-1:0]           elig;
    logic [NUM_REQ-1:0]           grant;
    logic [$clog2(NUM_REQ)-1:0]   unused_rr_ptr;
    logic                         transfer;
    logic                         lcrd_return;
    logic                         send;
    logic [FLIT_W-1:0]            sel_flit;

    // Credits are only granted by the receiver while the link is not stopped.
    assign lcrd_in = txlcrdv && (state != STOP);

`ifdef CHI_TX_SCHED_RESV_EN
    logic [4:0] avail;
    assign avail = {1'b0, credits} + {4'b0, lcrd_in};
    // Requester 0 may always spend the last credit so responses cannot deadlock.
    always_comb begin
        elig    = {NUM_REQ{avail >= 5'd2}};
        elig[0] = (avail >= 5'd1);
    end
`else
    assign elig = {NUM_REQ{(credits != 4'd0) || lcrd_in}};
`endif

    chi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req_valid & elig),
        .enable  ((state == RUN) && link_en),
        .advance (transfer),
        .grant   (grant),
        .ptr     (unused_rr_ptr)
    );

    assign req_ready   = grant;
    assign transfer    = |grant;
    assign lcrd_return = (state == DEACTIVATE) && (credits != 4'd0);
    assign send        = transfer || lcrd_return;

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i])
                sel_flit = sel_flit | req_flit[i*FLIT_W +: FLIT_W];
        if (lcrd_return)
            sel_flit[6:0] = LCRD_RETURN_OPCODE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= STOP;
            txlinkactivereq <= 1'b0;
            txflitpend      <= 1'b0;
        end else begin
            case (state)
                STOP: if (link_en) begin
                    state           <= ACTIVATE;
                    txlinkactivereq <= 1'b1;
                    txflitpend      <= 1'b1;
                end
                ACTIVATE: if (txlinkactiveack)
                    state <= RUN;
                RUN: if (!link_en) begin
                    state           <= DEACTIVATE;
                    txlinkactivereq <= 1'b0;
                end
                DEACTIVATE: if (!txlinkactiveack && credits == 4'd0) begin
                    state      <= STOP;
                    txflitpend <= 1'b0;
                end
                default: state <= STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credits    <= 4'd0;
            credit_err <= 1'b0;
            txflitv    <= 1'b0;
            txflit     <= '0;
        end else begin
            case ({lcrd_in, send})
                2'b10: begin
                    if (credits == CRED_MAX)
                        credit_err <= 1'b1;
                    else
                        credits <= credits + 4'd1;
                end
                2'b01:   credits <= credits - 4'd1;
                default: credits <= credits;
            endcase
            txflitv <= send;
            txflit  <= sel_flit;
        end
    end

    assign cur_credits = credits;
    assign link_state  = state;

endmodule
